// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared state encoding, width defaults and alignment helper for the fetch unit
package instruction_fetch_pkg;

    localparam int ADDR_W_DEFAULT  = 64;
    localparam int INSTR_W_DEFAULT = 32;

    // Instructions are 4-byte aligned; any of these bits set in a target PC is a fault.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter register, reloaded with the reset vector on reset
module pc_register #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              load,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            pc <= start_pc;
        end else if (load) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch FSM with hold, retire count and misalignment fault
module instruction_fetch_unit
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [ADDR_W-1:0]  StartPC,
    input  logic [ADDR_W-1:0]  NextPC,
    input  logic               PCWrite,
    output logic               IMemReqValid,
    input  logic               IMemReqReady,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemRespValid,
    input  logic [INSTR_W-1:0] IMemRespData,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic [ADDR_W-1:0]  CurrentPC,
    output logic               Misaligned,
    output logic [31:0]        FetchCount
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         retire;
    logic         bad_target;

    // PCWrite only has meaning while an instruction is being held for the core.
    assign retire     = (state == HOLD) && PCWrite;
    assign bad_target = is_misaligned(NextPC[1:0]);
    assign IMemAddr   = CurrentPC;

    pc_register #(
        .ADDR_W (ADDR_W)
    ) u_pc_register (
        .clk      (CLK),
        .reset_l  (Reset_L),
        .start_pc (StartPC),
        .load     (retire),
        .next_pc  (NextPC),
        .pc       (CurrentPC)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state       <= IDLE;
            Instruction <= '0;
            Misaligned  <= 1'b0;
            FetchCount  <= '0;
        end else begin
            state <= state_next;
            if (state == WAIT && IMemRespValid) begin
                Instruction <= IMemRespData;
            end
            if (retire) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (retire && bad_target) begin
                Misaligned <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        IMemReqValid = 1'b0;
        InstrValid   = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                IMemReqValid = 1'b1;
                if (IMemReqReady) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (IMemRespValid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                InstrValid = 1'b1;
                if (PCWrite) begin
                    state_next = bad_target ? FAULT : REQ;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [63:0] StartPC;
    logic [63:0] NextPC;
    logic        PCWrite;
    logic        IMemReqValid;
    logic        IMemReqReady;
    logic [63:0] IMemAddr;
    logic        IMemRespValid;
    logic [31:0] IMemRespData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [63:0] CurrentPC;
    logic        Misaligned;
    logic [31:0] FetchCount;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];

    instruction_fetch_unit #(
        .ADDR_W  (64),
        .INSTR_W (32)
    ) dut (
        .CLK           (CLK),
        .Reset_L       (Reset_L),
        .StartPC       (StartPC),
        .NextPC        (NextPC),
        .PCWrite       (PCWrite),
        .IMemReqValid  (IMemReqValid),
        .IMemReqReady  (IMemReqReady),
        .IMemAddr      (IMemAddr),
        .IMemRespValid (IMemRespValid),
        .IMemRespData  (IMemRespData),
        .Instruction   (Instruction),
        .InstrValid    (InstrValid),
        .CurrentPC     (CurrentPC),
        .Misaligned    (Misaligned),
        .FetchCount    (FetchCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; returns at the falling edge of the first HOLD cycle.
    task automatic fetch(input logic [63:0] addr, input logic [31:0] data, input int stall,
                         input int exp_wait, input bit junk_in_hs, input bit pcw_in_wait);
        int waited;
        logic [31:0] exp_instr;
        waited = 0;
        while (IMemReqValid !== 1'b1 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check("req_valid", 64'(IMemReqValid), 64'd1);
        if (exp_wait >= 0) check("req_latency", 64'(waited), 64'(exp_wait));
        check("req_addr", IMemAddr, addr);
        for (int i = 1; i < stall; i++) begin
            @(negedge CLK);
            check("stall_valid", 64'(IMemReqValid), 64'd1);
            check("stall_addr", IMemAddr, addr);
        end
        IMemReqReady = 1'b1;
        if (junk_in_hs) begin
            IMemRespValid = 1'b1;
            IMemRespData  = 32'hDEAD_BEEF;
        end
        @(negedge CLK);
        check("wait_no_req", 64'(IMemReqValid), 64'd0);
        check("wait_no_instr_valid", 64'(InstrValid), 64'd0);
        IMemRespValid = 1'b1;
        IMemRespData  = data;
        exp_q.push_back(data);
        if (pcw_in_wait) begin
            PCWrite = 1'b1;
            NextPC  = 64'h100;
        end
        @(negedge CLK);
        IMemRespValid = 1'b0;
        IMemRespData  = '0;
        PCWrite       = 1'b0;
        check("hold_valid", 64'(InstrValid), 64'd1);
        exp_instr = exp_q.pop_front();
        check("instruction", 64'(Instruction), 64'(exp_instr));
        check("hold_pc", CurrentPC, addr);
    endtask

    task automatic retire(input logic [63:0] target);
        PCWrite = 1'b1;
        NextPC  = target;
        @(negedge CLK);
        PCWrite = 1'b0;
    endtask

    initial begin
        Reset_L       = 1'b0;
        StartPC       = 64'h10;
        NextPC        = '0;
        PCWrite       = 1'b0;
        IMemReqReady  = 1'b1;
        IMemRespValid = 1'b0;
        IMemRespData  = '0;
        repeat (2) @(negedge CLK);

        check("rst_req_valid", 64'(IMemReqValid), 64'd0);
        check("rst_instr_valid", 64'(InstrValid), 64'd0);
        check("rst_instruction", 64'(Instruction), 64'd0);
        check("rst_pc", CurrentPC, 64'h10);
        check("rst_misaligned", 64'(Misaligned), 64'd0);
        check("rst_fetch_count", 64'(FetchCount), 64'd0);

        // Release, then exactly one IDLE cycle before the request appears.
        Reset_L = 1'b1;
        @(negedge CLK);
        fetch(64'h10, 32'h8B02_0020, 0, 0, 1'b1, 1'b0);

        @(negedge CLK);
        check("hold_stable_valid", 64'(InstrValid), 64'd1);
        check("hold_stable_instr", 64'(Instruction), 64'h8B02_0020);
        check("hold_no_req", 64'(IMemReqValid), 64'd0);

        IMemReqReady = 1'b0;
        retire(64'h14);
        check("b2b_req_valid", 64'(IMemReqValid), 64'd1);
        check("b2b_addr", IMemAddr, 64'h14);
        check("b2b_instr_valid", 64'(InstrValid), 64'd0);
        check("b2b_fetch_count", 64'(FetchCount), 64'd1);
        fetch(64'h14, 32'h00A0_0093, 3, 0, 1'b0, 1'b1);
        check("pcwrite_outside_hold_count", 64'(FetchCount), 64'd1);

        retire(64'h18);
        fetch(64'h18, 32'h0010_8113, 0, 0, 1'b0, 1'b0);
        retire(64'h20);
        fetch(64'h20, 32'hFE00_08E3, 0, 0, 1'b0, 1'b0);
        retire(64'h24);
        check("four_retired_count", 64'(FetchCount), 64'd4);
        fetch(64'h24, 32'h0000_0013, 0, 0, 1'b0, 1'b0);

        retire(64'h16);
        check("fault_misaligned", 64'(Misaligned), 64'd1);
        check("fault_pc", CurrentPC, 64'h16);
        check("fault_req_valid", 64'(IMemReqValid), 64'd0);
        check("fault_instr_valid", 64'(InstrValid), 64'd0);
        PCWrite = 1'b1;
        NextPC  = 64'h30;
        IMemRespValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("fault_stuck_req", 64'(IMemReqValid), 64'd0);
            check("fault_stuck_pc", CurrentPC, 64'h16);
            check("fault_stuck_misaligned", 64'(Misaligned), 64'd1);
        end
        PCWrite = 1'b0;
        IMemRespValid = 1'b0;

        StartPC = 64'h40;
        Reset_L = 1'b0;
        @(negedge CLK);
        Reset_L = 1'b1;
        check("rst2_misaligned", 64'(Misaligned), 64'd0);
        check("rst2_instruction", 64'(Instruction), 64'd0);
        check("rst2_pc", CurrentPC, 64'h40);
        @(negedge CLK);
        check("rst2_req_valid", 64'(IMemReqValid), 64'd1);
        @(negedge CLK);
        check("rst2_in_wait", 64'(IMemReqValid), 64'd0);

        // Reset while a fetch is outstanding.
        Reset_L = 1'b0;
        @(negedge CLK);
        check("midwait_req_valid", 64'(IMemReqValid), 64'd0);
        check("midwait_instr_valid", 64'(InstrValid), 64'd0);
        check("midwait_instruction", 64'(Instruction), 64'd0);
        check("midwait_pc", CurrentPC, 64'h40);
        check("midwait_fetch_count", 64'(FetchCount), 64'd0);
        check("midwait_misaligned", 64'(Misaligned), 64'd0);
        Reset_L = 1'b1;
        @(negedge CLK);
        fetch(64'h40, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
        retire(64'h44);
        check("restart_fetch_count", 64'(FetchCount), 64'd1);
        check("restart_req_addr", IMemAddr, 64'h44);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
